// File: rtl/xbar_nxm_if.sv
// AXI4-Lite channel bundle shared by the crossbar's upstream and downstream ports.
// Latency: none, wires only.
// Backpressure: each channel is a standard valid/ready pair.
// Ports: ar/r, aw/w/b channels; wmask is DATA_WIDTH/8 bits, rresp/bresp are 2 bits.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wmask;
   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;

   modport master (
      output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
      input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
      output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/xbar_nxm.sv
// AXI4-Lite NxM crossbar: independent round-robin read and write paths, one transaction each, DECERR for unmapped addresses.
// Latency: +1 cycle on AR and AW/W (grant register), 0 added cycles on R and B.
// Backpressure: slave readies pass combinationally to the granted master; other masters see ready=0 until granted.
// Ports: clk, reset_n (async active-low); m[NUM_MASTERS] upstream (slave modport); s[NUM_SLAVES] downstream (master modport).
// Map: slave j owns [SLAVE_BASE[j], SLAVE_BASE[j]+SLAVE_SIZE[j]); default index 0 is SRAM at 0x80000000, index 1 the UART at 0xa00003f8.
module xbar_nxm #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = {32'ha00003f8, 32'h80000000},
   parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_SIZE = {32'h00000004, 32'h08000000}
) (
   input logic        clk,
   input logic        reset_n,
   axi_lite_if.slave  m [NUM_MASTERS],
   axi_lite_if.master s [NUM_SLAVES]
);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_ERR} w_state_t;

   // Flattened views of the interface arrays so the granted index can be variable.
   logic [NUM_MASTERS-1:0]                 m_arvalid, m_arready, m_rvalid, m_rready;
   logic [NUM_MASTERS-1:0]                 m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_araddr, m_awaddr;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata, m_wdata;
   logic [NUM_MASTERS-1:0][BW-1:0]         m_wmask;
   logic [NUM_MASTERS-1:0][1:0]            m_rresp, m_bresp;

   logic [NUM_SLAVES-1:0]                  s_arvalid, s_arready, s_rvalid, s_rready;
   logic [NUM_SLAVES-1:0]                  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_rdata;
   logic [NUM_SLAVES-1:0][1:0]             s_rresp, s_bresp;

   r_state_t              r_state;
   logic [MW-1:0]         r_gnt, r_ptr, r_pick;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_hit;
   logic [SW-1:0]         r_sel;

   w_state_t              w_state;
   logic [MW-1:0]         w_gnt, w_ptr, w_pick;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_hit;
   logic [SW-1:0]         w_sel;
   logic                  aw_done, w_done, aw_hs, w_hs;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
      assign m_arvalid[i] = m[i].arvalid;
      assign m_araddr[i]  = m[i].araddr;
      assign m_rready[i]  = m[i].rready;
      assign m_awvalid[i] = m[i].awvalid;
      assign m_awaddr[i]  = m[i].awaddr;
      assign m_wvalid[i]  = m[i].wvalid;
      assign m_wdata[i]   = m[i].wdata;
      assign m_wmask[i]   = m[i].wmask;
      assign m_bready[i]  = m[i].bready;
      assign m[i].arready = m_arready[i];
      assign m[i].rvalid  = m_rvalid[i];
      assign m[i].rdata   = m_rdata[i];
      assign m[i].rresp   = m_rresp[i];
      assign m[i].awready = m_awready[i];
      assign m[i].wready  = m_wready[i];
      assign m[i].bvalid  = m_bvalid[i];
      assign m[i].bresp   = m_bresp[i];
   end

   for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_s
      assign s_arready[j] = s[j].arready;
      assign s_rvalid[j]  = s[j].rvalid;
      assign s_rdata[j]   = s[j].rdata;
      assign s_rresp[j]   = s[j].rresp;
      assign s_awready[j] = s[j].awready;
      assign s_wready[j]  = s[j].wready;
      assign s_bvalid[j]  = s[j].bvalid;
      assign s_bresp[j]   = s[j].bresp;
      assign s[j].arvalid = s_arvalid[j];
      assign s[j].araddr  = r_addr;
      assign s[j].rready  = s_rready[j];
      assign s[j].awvalid = s_awvalid[j];
      assign s[j].awaddr  = w_addr;
      assign s[j].wvalid  = s_wvalid[j];
      assign s[j].wdata   = m_wdata[w_gnt];
      assign s[j].wmask   = m_wmask[w_gnt];
      assign s[j].bready  = s_bready[j];
   end

   // End of region is computed one bit wider so a region touching the top of the space does not wrap.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr, input logic [SW-1:0] j);
      logic [ADDR_WIDTH:0] lo, hi;
      lo = {1'b0, SLAVE_BASE[j]};
      hi = lo + {1'b0, SLAVE_SIZE[j]};
      return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
   endfunction

   // First requester at or after ptr, searching cyclically.
   function automatic logic [MW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [MW-1:0] ptr);
      logic [MW-1:0] pick, idx;
      logic          found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = MW'((int'(ptr) + k) % NUM_MASTERS);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [MW-1:0] rr_next(input logic [MW-1:0] g);
      return MW'((int'(g) + 1) % NUM_MASTERS);
   endfunction

   assign r_pick = rr_pick(m_arvalid, r_ptr);
   assign w_pick = rr_pick(m_awvalid, w_ptr);

   // Descending scan so the lowest matching index wins on overlap.
   always_comb begin
      r_hit = 1'b0;
      r_sel = '0;
      w_hit = 1'b0;
      w_sel = '0;
      for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
         if (in_range(r_addr, SW'(j))) begin
            r_hit = 1'b1;
            r_sel = SW'(j);
         end
         if (in_range(w_addr, SW'(j))) begin
            w_hit = 1'b1;
            w_sel = SW'(j);
         end
      end
   end

   // ---------------- read path ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= R_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (|m_arvalid) begin
               r_gnt   <= r_pick;
               r_addr  <= m_araddr[r_pick];
               r_ptr   <= rr_next(r_pick);
               r_state <= R_ADDR;
            end
            R_ADDR: begin
               if (!r_hit)                 r_state <= R_ERR;
               else if (s_arready[r_sel])  r_state <= R_DATA;
            end
            R_DATA: if (s_rvalid[r_sel] && m_rready[r_gnt]) r_state <= R_IDLE;
            R_ERR:  if (m_rready[r_gnt]) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      s_arvalid = '0;
      s_rready  = '0;
      case (r_state)
         R_ADDR: begin
            if (r_hit) begin
               s_arvalid[r_sel] = 1'b1;
               m_arready[r_gnt] = s_arready[r_sel];
            end else begin
               // Unmapped: swallow the AR beat here; the error response follows.
               m_arready[r_gnt] = 1'b1;
            end
         end
         R_DATA: begin
            m_rvalid[r_gnt] = s_rvalid[r_sel];
            m_rdata[r_gnt]  = s_rdata[r_sel];
            m_rresp[r_gnt]  = s_rresp[r_sel];
            s_rready[r_sel] = m_rready[r_gnt];
         end
         R_ERR: begin
            m_rvalid[r_gnt] = 1'b1;
            m_rresp[r_gnt]  = 2'b11;
         end
         default: ;
      endcase
   end

   // ---------------- write path ----------------
   // AW and W may complete in either order; the done flags remember which already fired.
   assign aw_hs = (w_state == W_XFER) && !aw_done &&
                  (w_hit ? s_awready[w_sel] : m_awvalid[w_gnt]);
   assign w_hs  = (w_state == W_XFER) && !w_done && m_wvalid[w_gnt] &&
                  (w_hit ? s_wready[w_sel] : 1'b1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state <= W_IDLE;
         w_gnt   <= '0;
         w_ptr   <= '0;
         w_addr  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: if (|m_awvalid) begin
               w_gnt   <= w_pick;
               w_addr  <= m_awaddr[w_pick];
               w_ptr   <= rr_next(w_pick);
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               w_state <= W_XFER;
            end
            W_XFER: begin
               aw_done <= aw_done | aw_hs;
               w_done  <= w_done | w_hs;
               if ((aw_done | aw_hs) && (w_done | w_hs))
                  w_state <= w_hit ? W_RESP : W_ERR;
            end
            W_RESP: if (s_bvalid[w_sel] && m_bready[w_gnt]) w_state <= W_IDLE;
            W_ERR:  if (m_bready[w_gnt]) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_bready  = '0;
      case (w_state)
         W_XFER: begin
            if (w_hit) begin
               s_awvalid[w_sel] = !aw_done;
               s_wvalid[w_sel]  = m_wvalid[w_gnt] && !w_done;
               m_awready[w_gnt] = s_awready[w_sel] && !aw_done;
               m_wready[w_gnt]  = s_wready[w_sel] && !w_done;
            end else begin
               m_awready[w_gnt] = !aw_done;
               m_wready[w_gnt]  = !w_done;
            end
         end
         W_RESP: begin
            m_bvalid[w_gnt] = s_bvalid[w_sel];
            m_bresp[w_gnt]  = s_bresp[w_sel];
            s_bready[w_sel] = m_bready[w_gnt];
         end
         W_ERR: begin
            m_bvalid[w_gnt] = 1'b1;
            m_bresp[w_gnt]  = 2'b11;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_xbar_nxm.sv
// Directed bench for xbar_nxm: 2 masters, 2 slaves (slave 0 at 0x80000000, slave 1 at 0xa00003f8).
// Inputs change 1 time unit after a rising edge; outputs are compared 2 units after it.
// Slave responses are driven cycle by cycle from the tasks.
module tb_xbar_nxm;
   logic clk;
   logic reset_n;
   int   vectors;
   int   misc;

   logic [1:0]       m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [1:0][31:0] m_araddr, m_awaddr, m_wdata;
   logic [1:0][3:0]  m_wmask;
   logic [1:0]       m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
   logic [1:0][31:0] m_rdata;
   logic [1:0][1:0]  m_rresp, m_bresp;

   logic [1:0]       s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [1:0][31:0] s_rdata;
   logic [1:0][1:0]  s_rresp, s_bresp;
   logic [1:0]       s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [1:0][31:0] s_araddr, s_awaddr, s_wdata;
   logic [1:0][3:0]  s_wmask;

   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif [2] ();
   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sif [2] ();

   for (genvar i = 0; i < 2; i++) begin : g_m
      assign mif[i].arvalid = m_arvalid[i];
      assign mif[i].araddr  = m_araddr[i];
      assign mif[i].rready  = m_rready[i];
      assign mif[i].awvalid = m_awvalid[i];
      assign mif[i].awaddr  = m_awaddr[i];
      assign mif[i].wvalid  = m_wvalid[i];
      assign mif[i].wdata   = m_wdata[i];
      assign mif[i].wmask   = m_wmask[i];
      assign mif[i].bready  = m_bready[i];
      assign m_arready[i] = mif[i].arready;
      assign m_rvalid[i]  = mif[i].rvalid;
      assign m_rdata[i]   = mif[i].rdata;
      assign m_rresp[i]   = mif[i].rresp;
      assign m_awready[i] = mif[i].awready;
      assign m_wready[i]  = mif[i].wready;
      assign m_bvalid[i]  = mif[i].bvalid;
      assign m_bresp[i]   = mif[i].bresp;
   end

   for (genvar j = 0; j < 2; j++) begin : g_s
      assign sif[j].arready = s_arready[j];
      assign sif[j].rvalid  = s_rvalid[j];
      assign sif[j].rdata   = s_rdata[j];
      assign sif[j].rresp   = s_rresp[j];
      assign sif[j].awready = s_awready[j];
      assign sif[j].wready  = s_wready[j];
      assign sif[j].bvalid  = s_bvalid[j];
      assign sif[j].bresp   = s_bresp[j];
      assign s_arvalid[j] = sif[j].arvalid;
      assign s_araddr[j]  = sif[j].araddr;
      assign s_rready[j]  = sif[j].rready;
      assign s_awvalid[j] = sif[j].awvalid;
      assign s_awaddr[j]  = sif[j].awaddr;
      assign s_wvalid[j]  = sif[j].wvalid;
      assign s_wdata[j]   = sif[j].wdata;
      assign s_wmask[j]   = sif[j].wmask;
      assign s_bready[j]  = sif[j].bready;
   end

   xbar_nxm #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m       (mif),
      .s       (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      m_arvalid = 2'b01;
      m_awvalid = 2'b10;
      m_araddr[0] = 32'h80000000;
      m_awaddr[1] = 32'h80000000;
      for (int k = 0; k < 2; k++) begin
         cyc;
         #1;
         vectors++;
         if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 10'b0) begin
            misc++;
            $display("FAIL reset_m_hs[%0d]: got %b exp 0", k, {m_arready, m_rvalid, m_awready, m_wready, m_bvalid});
         end
         vectors++;
         if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 10'b0) begin
            misc++;
            $display("FAIL reset_s_hs[%0d]: got %b exp 0", k, {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
         end
         vectors++;
         if ({m_rdata, m_rresp, m_bresp} !== 72'h0) begin
            misc++;
            $display("FAIL reset_m_data[%0d]: got %h exp 0", k, {m_rdata, m_rresp, m_bresp});
         end
      end
      m_arvalid = 2'b00;
      m_awvalid = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      cyc;
      #1;
      vectors++;
      if ({m_arready, m_awready} !== 4'b0) begin
         misc++;
         $display("FAIL post_reset_idle: got %b exp 0", {m_arready, m_awready});
      end
   endtask

   task automatic test_rr_read;
      logic [31:0] tag;
      logic        gi;
      logic [1:0]  oh;
      s_arready = 2'b01;
      m_rready  = 2'b11;
      cyc;
      m_araddr[0] = 32'h80000000;
      m_araddr[1] = 32'h80000000;
      m_arvalid   = 2'b11;
      for (int i = 0; i < 4; i++) begin
         gi  = (i % 2 == 1);
         oh  = gi ? 2'b10 : 2'b01;
         tag = 32'h11 * (i + 1);
         cyc;
         vectors++;
         if (m_arready !== oh || s_arvalid !== 2'b01 || s_araddr[0] !== 32'h80000000) begin
            misc++;
            $display("FAIL rr_addr[%0d]: got arready=%b s_arvalid=%b araddr=%h exp %b 01 80000000", i, m_arready, s_arvalid, s_araddr[0], oh);
         end
         cyc;
         s_rvalid   = 2'b01;
         s_rdata[0] = tag;
         #1;
         vectors++;
         if (m_rvalid !== oh || m_rdata[gi] !== tag || m_rdata[~gi] !== 32'h0) begin
            misc++;
            $display("FAIL rr_data[%0d]: got rvalid=%b rdata=%h other=%h exp %b %h 0", i, m_rvalid, m_rdata[gi], m_rdata[~gi], oh, tag);
         end
         cyc;
         s_rvalid = 2'b00;
         if (i == 3) m_arvalid = 2'b00;
         #1;
         vectors++;
         if ({m_rvalid, m_arready, s_arvalid} !== 6'b0) begin
            misc++;
            $display("FAIL rr_idle[%0d]: got %b exp 0", i, {m_rvalid, m_arready, s_arvalid});
         end
      end
   endtask

   task automatic test_unmapped_read;
      cyc;
      m_araddr[1] = 32'h00001000;
      m_arvalid   = 2'b10;
      m_rready    = 2'b10;
      cyc;
      vectors++;
      if (m_arready !== 2'b10 || s_arvalid !== 2'b00) begin
         misc++;
         $display("FAIL decerr_rd_ar: got arready=%b s_arvalid=%b exp 10 00", m_arready, s_arvalid);
      end
      cyc;
      m_arvalid = 2'b00;
      m_rready  = 2'b00;
      #1;
      vectors++;
      if (m_rvalid !== 2'b10 || m_rresp[1] !== 2'b11 || m_rdata[1] !== 32'h0 || s_arvalid !== 2'b00) begin
         misc++;
         $display("FAIL decerr_rd_r: got rvalid=%b rresp=%b rdata=%h s_arvalid=%b exp 10 11 0 00", m_rvalid, m_rresp[1], m_rdata[1], s_arvalid);
      end
      cyc;
      vectors++;
      if (m_rvalid !== 2'b10 || m_rresp[1] !== 2'b11) begin
         misc++;
         $display("FAIL decerr_rd_hold: got rvalid=%b rresp=%b exp 10 11", m_rvalid, m_rresp[1]);
      end
      m_rready = 2'b10;
      cyc;
      vectors++;
      if (m_rvalid !== 2'b00 || s_arvalid !== 2'b00) begin
         misc++;
         $display("FAIL decerr_rd_done: got rvalid=%b s_arvalid=%b exp 00 00", m_rvalid, s_arvalid);
      end
   endtask

   task automatic test_write_ordering;
      s_awready = 2'b00;
      s_wready  = 2'b10;
      m_bready  = 2'b01;
      cyc;
      m_awaddr[0] = 32'ha00003f8;
      m_wdata[0]  = 32'h41;
      m_wmask[0]  = 4'b0001;
      m_awvalid   = 2'b01;
      m_wvalid    = 2'b00;
      for (int k = 1; k <= 2; k++) begin
         cyc;
         vectors++;
         if (s_awvalid !== 2'b10 || s_wvalid !== 2'b00 || m_awready !== 2'b00 || s_awaddr[1] !== 32'ha00003f8) begin
            misc++;
            $display("FAIL wr_aw_wait[%0d]: got s_awvalid=%b s_wvalid=%b awready=%b awaddr=%h exp 10 00 00 a00003f8", k, s_awvalid, s_wvalid, m_awready, s_awaddr[1]);
         end
      end
      cyc;
      m_wvalid  = 2'b01;
      s_awready = 2'b10;
      #1;
      vectors++;
      if (s_wvalid !== 2'b10 || s_wdata[1] !== 32'h41 || s_wmask[1] !== 4'b0001 || m_awready !== 2'b01 || m_wready !== 2'b01) begin
         misc++;
         $display("FAIL wr_beats: got s_wvalid=%b wdata=%h wmask=%b awready=%b wready=%b exp 10 41 0001 01 01", s_wvalid, s_wdata[1], s_wmask[1], m_awready, m_wready);
      end
      cyc;
      m_awvalid  = 2'b00;
      m_wvalid   = 2'b00;
      s_bvalid   = 2'b10;
      s_bresp[1] = 2'b00;
      #1;
      vectors++;
      if (m_bvalid !== 2'b01 || m_bresp[0] !== 2'b00 || s_bready !== 2'b10 || {s_awvalid, s_wvalid} !== 4'b0) begin
         misc++;
         $display("FAIL wr_bresp: got bvalid=%b bresp=%b s_bready=%b s_aw_w=%b exp 01 00 10 0000", m_bvalid, m_bresp[0], s_bready, {s_awvalid, s_wvalid});
      end
      cyc;
      s_bvalid = 2'b00;
      #1;
      vectors++;
      if (m_bvalid !== 2'b00) begin
         misc++;
         $display("FAIL wr_done: got bvalid=%b exp 00", m_bvalid);
      end
   endtask

   task automatic test_unmapped_write;
      cyc;
      m_awaddr[1] = 32'h00002000;
      m_wdata[1]  = 32'hff;
      m_wmask[1]  = 4'hf;
      m_awvalid   = 2'b10;
      m_wvalid    = 2'b10;
      m_bready    = 2'b10;
      cyc;
      vectors++;
      if (m_awready !== 2'b10 || m_wready !== 2'b10 || {s_awvalid, s_wvalid} !== 4'b0) begin
         misc++;
         $display("FAIL decerr_wr_xfer: got awready=%b wready=%b s_aw_w=%b exp 10 10 0000", m_awready, m_wready, {s_awvalid, s_wvalid});
      end
      cyc;
      m_awvalid = 2'b00;
      m_wvalid  = 2'b00;
      #1;
      vectors++;
      if (m_bvalid !== 2'b10 || m_bresp[1] !== 2'b11) begin
         misc++;
         $display("FAIL decerr_wr_b: got bvalid=%b bresp=%b exp 10 11", m_bvalid, m_bresp[1]);
      end
      cyc;
      vectors++;
      if (m_bvalid !== 2'b00) begin
         misc++;
         $display("FAIL decerr_wr_done: got bvalid=%b exp 00", m_bvalid);
      end
   endtask

   task automatic test_concurrent;
      s_arready = 2'b01;
      s_awready = 2'b01;
      s_wready  = 2'b01;
      m_rready  = 2'b01;
      m_bready  = 2'b10;
      cyc;
      m_araddr[0] = 32'h80000010;
      m_arvalid   = 2'b01;
      m_awaddr[1] = 32'h80000020;
      m_wdata[1]  = 32'hcafe0001;
      m_wmask[1]  = 4'hf;
      m_awvalid   = 2'b10;
      m_wvalid    = 2'b10;
      cyc;
      vectors++;
      if (s_arvalid !== 2'b01 || s_araddr[0] !== 32'h80000010 || s_awvalid !== 2'b01 || s_wvalid !== 2'b01 ||
          s_awaddr[0] !== 32'h80000020 || s_wdata[0] !== 32'hcafe0001) begin
         misc++;
         $display("FAIL conc_slave: got ar=%b %h aw=%b %h w=%b %h exp 01 80000010 01 80000020 01 cafe0001", s_arvalid, s_araddr[0], s_awvalid, s_awaddr[0], s_wvalid, s_wdata[0]);
      end
      vectors++;
      if (m_arready !== 2'b01 || m_awready !== 2'b10 || m_wready !== 2'b10) begin
         misc++;
         $display("FAIL conc_ready: got arready=%b awready=%b wready=%b exp 01 10 10", m_arready, m_awready, m_wready);
      end
      cyc;
      m_arvalid  = 2'b00;
      m_awvalid  = 2'b00;
      m_wvalid   = 2'b00;
      s_rvalid   = 2'b01;
      s_rdata[0] = 32'h55;
      s_bvalid   = 2'b01;
      s_bresp[0] = 2'b00;
      #1;
      vectors++;
      if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'h55 || m_bvalid !== 2'b10 || s_rready !== 2'b01 || s_bready !== 2'b01) begin
         misc++;
         $display("FAIL conc_resp: got rvalid=%b rdata=%h bvalid=%b s_rready=%b s_bready=%b exp 01 55 10 01 01", m_rvalid, m_rdata[0], m_bvalid, s_rready, s_bready);
      end
      cyc;
      s_rvalid = 2'b00;
      s_bvalid = 2'b00;
      #1;
      vectors++;
      if ({m_rvalid, m_bvalid} !== 4'b0) begin
         misc++;
         $display("FAIL conc_done: got %b exp 0000", {m_rvalid, m_bvalid});
      end
   endtask

   task automatic test_reset_mid;
      s_arready = 2'b01;
      m_rready  = 2'b01;
      cyc;
      m_araddr[0] = 32'h80000000;
      m_arvalid   = 2'b01;
      cyc;
      vectors++;
      if (m_arready !== 2'b01) begin
         misc++;
         $display("FAIL rst_mid_ar: got arready=%b exp 01", m_arready);
      end
      cyc;
      m_arvalid  = 2'b00;
      s_rvalid   = 2'b01;
      s_rdata[0] = 32'hdead0001;
      #1;
      vectors++;
      if (m_rvalid !== 2'b01) begin
         misc++;
         $display("FAIL rst_mid_pending: got rvalid=%b exp 01", m_rvalid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({m_rvalid, m_arready, s_rready, s_arvalid} !== 8'b0 || m_rdata[0] !== 32'h0) begin
         misc++;
         $display("FAIL rst_mid_async: got %b rdata=%h exp 0 0", {m_rvalid, m_arready, s_rready, s_arvalid}, m_rdata[0]);
      end
      cyc;
      vectors++;
      if ({m_rvalid, s_rready} !== 4'b0) begin
         misc++;
         $display("FAIL rst_mid_hold: got %b exp 0000", {m_rvalid, s_rready});
      end
      s_rvalid = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      cyc;
      m_araddr[0] = 32'h80000004;
      m_araddr[1] = 32'h80000008;
      m_rready    = 2'b11;
      m_arvalid   = 2'b11;
      cyc;
      vectors++;
      if (m_arready !== 2'b01 || s_araddr[0] !== 32'h80000004) begin
         misc++;
         $display("FAIL rst_ptr_restart: got arready=%b araddr=%h exp 01 80000004", m_arready, s_araddr[0]);
      end
      cyc;
      m_arvalid  = 2'b10;
      s_rvalid   = 2'b01;
      s_rdata[0] = 32'h0000beef;
      #1;
      vectors++;
      if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'h0000beef) begin
         misc++;
         $display("FAIL rst_new_read: got rvalid=%b rdata=%h exp 01 0000beef", m_rvalid, m_rdata[0]);
      end
      cyc;
      s_rvalid = 2'b00;
      #1;
      vectors++;
      if (m_rvalid !== 2'b00) begin
         misc++;
         $display("FAIL rst_new_idle: got rvalid=%b exp 00", m_rvalid);
      end
      cyc;
      vectors++;
      if (m_arready !== 2'b10 || s_araddr[0] !== 32'h80000008) begin
         misc++;
         $display("FAIL rst_next_grant: got arready=%b araddr=%h exp 10 80000008", m_arready, s_araddr[0]);
      end
      cyc;
      m_arvalid  = 2'b00;
      s_rvalid   = 2'b01;
      s_rdata[0] = 32'h77;
      #1;
      vectors++;
      if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'h77) begin
         misc++;
         $display("FAIL rst_m1_read: got rvalid=%b rdata=%h exp 10 77", m_rvalid, m_rdata[1]);
      end
      cyc;
      s_rvalid = 2'b00;
   endtask

   initial begin
      vectors   = 0;
      misc      = 0;
      reset_n   = 1'b0;
      m_arvalid = '0;
      m_rready  = '0;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      m_araddr  = '0;
      m_awaddr  = '0;
      m_wdata   = '0;
      m_wmask   = '0;
      s_arready = '0;
      s_rvalid  = '0;
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_bresp   = '0;

      test_reset;
      test_rr_read;
      test_unmapped_read;
      test_write_ordering;
      test_unmapped_write;
      test_concurrent;
      test_reset_mid;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end
endmodule

// File: doc/xbar_nxm.md
# xbar_nxm

Parametrised AXI4-Lite crossbar connecting NUM_MASTERS masters (e.g. IFU, LSU) to NUM_SLAVES address-mapped slaves (SRAM, UART, CLINT, ...). Read and write paths are independent. Each path arbitrates round-robin among its requesting masters and carries one outstanding transaction at a time. Accesses to an unmapped address complete inside the block with DECERR, so masters never hang.

## Interface
- NUM_MASTERS, 2: number of upstream masters (>=1).
- NUM_SLAVES, 2: number of downstream slaves (>=1).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; wmask is DATA_WIDTH/8 bits.
- SLAVE_BASE, {32'h80000000, 32'ha00003f8}: per-slave base address, packed [NUM_SLAVES-1:0][ADDR_WIDTH-1:0].
- SLAVE_SIZE, {32'h08000000, 32'h00000004}: per-slave region size in bytes, same packing.
- clk  input  1  clock; everything is sampled on the rising edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- m  axi_lite_if.slave  [NUM_MASTERS]  upstream ports (ar/r/aw/w/b, wmask, rresp/bresp 2 bits).
- s  axi_lite_if.master  [NUM_SLAVES]  downstream ports.

## Operation
- **Decode**
  - Slave j matches when SLAVE_BASE[j] <= addr < SLAVE_BASE[j]+SLAVE_SIZE[j]. The sum is computed in ADDR_WIDTH+1 bits, so there is no wrap.
  - If multiple slaves match, the lowest index wins.
  - No match means decode error.
- **Arbitration (per path)**
  - rr_ptr is in 0..NUM_MASTERS-1, reset 0.
  - In the idle state, grant goes to the first requesting master at or after rr_ptr, searching cyclically. Requests are arvalid for the read path and awvalid for the write path.
  - On grant to g, the block latches g and the address, and sets rr_ptr <= (g+1) mod NUM_MASTERS.
- **Read FSM**
  - R_IDLE: if any arvalid, grant, then go to R_ADDR.
  - R_ADDR, slave matched: s[sel].arvalid=1 with the latched address. m[g].arready = s[sel].arready. When that handshake fires, go to R_DATA.
  - R_ADDR, no match: m[g].arready=1 for one cycle, then go to R_ERR.
  - R_DATA: m[g].rvalid/rdata/rresp are driven from s[sel], and s[sel].rready = m[g].rready. On the r handshake, go to R_IDLE.
  - R_ERR: m[g].rvalid=1, rdata=0, rresp=2'b11 until rready, then go to R_IDLE.
- **Write FSM**
  - W_IDLE: if any awvalid, grant, then go to W_XFER. Flags aw_done and w_done are cleared.
  - W_XFER, slave matched:
    - s[sel].awvalid = !aw_done.
    - s[sel].wvalid = m[g].wvalid && !w_done; wdata and wmask pass through.
    - m[g].awready and m[g].wready mirror the slave readies, gated by their done flags.
    - When both handshakes have completed (in the same or different cycles), go to W_RESP.
  - W_XFER, no match: the AW and W beats are accepted from m[g] (awready=1 while !aw_done, wready=1 while !w_done) and no slave is touched. When both are done, go to W_ERR.
  - W_RESP: b-channel pass-through between s[sel] and m[g]. On the b handshake, go to W_IDLE.
  - W_ERR: m[g].bvalid=1, bresp=2'b11 until bready, then go to W_IDLE.
- **Non-granted ports:** all ready/valid outputs are 0, and rdata/rresp/bresp are 0. Slaves not selected see valid=0 and ready=0; their address/data buses may carry any value.

## Timing
- **Reset:** asynchronous assert. States go to R_IDLE/W_IDLE, rr_ptrs to 0, flags to 0, and every valid/ready output to 0 immediately. Deassertion is synchronous to clk.
  - Reset mid-transaction abandons it. No response is produced.
- **Read latency:** arvalid in cycle 0 leads to grant at the cycle-0 edge. s.arvalid is asserted in cycle 1. m.arready equals s.arready combinationally. So there is +1 cycle on AR, and 0 added cycles on R.
- **Write latency:** +1 cycle on AW/W; 0 added cycles on B.
- **DECERR timing:** read gives arready in cycle 1 and rvalid from cycle 2. Write gives bvalid the cycle after the last of AW/W completes.
- **Back-to-back:** the idle state is re-entered for one cycle between transactions on the same path. Minimum spacing is 3 cycles for reads.
- **Independence:** read and write paths never stall each other. Both may target the same slave concurrently.
- **Master-side rule:** a master's valid, once asserted, is held until its handshake, as AXI requires. The grant depends only on valid.

## Test plan
- **Round-robin read:** NUM_MASTERS=2, both masters assert arvalid to 0x80000000 every cycle. Grants alternate m0, m1, m0, m1, and each receives the slave-0 rdata tagged to its own request.
- **Unmapped read:** m1 reads 0x00001000. m1.rresp=2'b11 and rdata=0 in cycle 2. No s[*].arvalid is ever asserted.
- **Write ordering:** m0 writes 0xa00003f8 with wdata=0x41, wmask=4'b0001. The W beat arrives 3 cycles after AW, and the slave holds awready low until wvalid. Slave 1 receives both beats, and bresp=0 is returned to m0 only.
- **Concurrent paths:** m0 reads slave 0 while m1 writes slave 0 simultaneously. Both complete with no added stall versus isolated runs.
- **Reset mid-operation:** reset_n is pulsed low during R_DATA with the slave rvalid pending. All outputs go to 0 asynchronously. After release, a new m0 read to 0x80000004 completes normally with rr_ptr restarted at 0.
